regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised successor to the single-cycle register file, for the pipelined CPU core. It provides NUM_READ combinational read ports, one synchronous write-back port and a per-register busy scoreboard. Decode uses the scoreboard to stall on RAW/WAW hazards. It also carries an outstanding-write counter and a sticky protocol-error flag. Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NUM_REGS)
NUM_READ, 2, number of read ports (>=1)
RESET_BASE, 3000, reset value of register i is RESET_BASE+i for i>=1; register 0 resets to 0

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rd_addr  input  NUM_READ*AW  read addresses, port p at [p*AW +: AW]
rd_data  output  NUM_READ*XLEN  read data, port p at [p*XLEN +: XLEN]
rd_busy  output  NUM_READ  bit p = scoreboard busy bit of rd_addr port p
issue_valid  input  1  decode requests to reserve destination issue_rd
issue_rd  input  AW  destination register to reserve
issue_ready  output  1  reservation accepted this cycle (combinational)
wb_valid  input  1  write-back strobe
wb_rd  input  AW  write-back destination
wb_data  input  XLEN  write-back data
pending_count  output  AW+1  number of registers currently busy
wb_err  output  1  sticky: write-back arrived for a non-busy register (rd != 0)
register_check  output  NUM_REGS*XLEN  flat view of all registers, reg i at [i*XLEN +: XLEN]

Behaviour:
- Reset (reset=0, asynchronous): reg[0]=0, reg[i]=RESET_BASE+i, all busy bits=0, pending_count=0, wb_err=0. Outputs follow immediately without waiting for a clock edge.
- Reads: combinational. rd_data[p] = reg[rd_addr[p]]; address 0 always reads 0. rd_busy[p] = busy[rd_addr[p]]; busy[0] is always 0.
- Write: on the rising edge with wb_valid=1 and wb_rd!=0, reg[wb_rd] <= wb_data and busy[wb_rd] <= 0. wb_rd=0 writes nothing and changes no state.
- Issue: issue_ready = issue_valid & ~busy[issue_rd], with the bypass exception below. issue_rd=0 is always ready and reserves nothing.
- On an accepted issue with rd!=0, busy[issue_rd] <= 1 on the rising edge. A rejected issue changes no state; decode holds the request and retries.
- Simultaneous issue and write-back to the same rd!=0: the register is written, and busy stays 1 because the new reservation wins. issue_ready for that rd follows the optional feature.
- pending_count tracks the popcount of busy bits. Per edge it changes by +1 for an accepted issue, -1 for a write-back that clears a busy bit, and 0 when both occur (or both target the same rd). It saturates at neither end because its width covers NUM_REGS.
- wb_err is set on the edge where wb_valid=1, wb_rd!=0 and busy[wb_rd]=0 (same-cycle issue not counted). The write still occurs. wb_err clears only on reset.
- Latency: a write is visible on read ports and register_check one cycle after the edge, unless bypass is enabled.

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If wb_valid=1 and wb_rd!=0 and rd_addr[p]==wb_rd, then rd_data[p]=wb_data and rd_busy[p]=0 in the same cycle.
- Defined: issue_ready also treats busy[issue_rd] as clear when wb_valid=1 and wb_rd==issue_rd.
- Not defined: reads return the stored value and stored busy bit. An issue to a register being written back in the same cycle is rejected.
- register_check is never bypassed in either build.

Test Plan:
1. Reset check: pulse reset low with no clock edge -> register_check[5]=3005, rd_data for addr 0 = 0, pending_count=0, wb_err=0.
2. Issue and write-back: issue rd=7 -> next cycle rd_busy=1 for addr 7 and pending_count=1. Then wb rd=7 data=6011 -> reg[7]=6011, busy cleared, pending_count=0.
3. WAW stall: with rd=10 busy, issue rd=10 -> issue_ready=0, pending_count unchanged. Then wb rd=10 data=1 -> reissue accepted next cycle.
4. x0 handling: issue rd=0 -> issue_ready=1 with no busy change. wb rd=0 data=32'hdeadbeef -> reg[0] still 0, wb_err=0.
5. Protocol error: wb rd=13 data=3013 while not busy -> reg[13]=3013 and wb_err=1, still 1 after further clean write-backs.
6. Same-cycle issue and write-back to rd=3:
   - Without REGFILE_BYPASS_EN: issue_ready=0 and busy[3]=0 after the edge.
   - With REGFILE_BYPASS_EN: issue_ready=1, rd_data for addr 3 = wb_data in the same cycle, busy[3]=1 after the edge, pending_count unchanged.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_READ combinational read ports, one write-back port, busy scoreboard, pending counter and sticky wb_err.
// Reads and issue_ready are combinational; writes land one edge later. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile_scoreboard #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter int RESET_BASE = 3000,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*AW-1:0]     rd_addr,
  output logic [NUM_READ*XLEN-1:0]   rd_data,
  output logic [NUM_READ-1:0]        rd_busy,
  input  logic                       issue_valid,
  input  logic [AW-1:0]              issue_rd,
  output logic                       issue_ready,
  input  logic                       wb_valid,
  input  logic [AW-1:0]              wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  output logic [AW:0]                pending_count,
  output logic                       wb_err,
  output logic [NUM_REGS*XLEN-1:0]   register_check
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                err_q, err_d;

  logic wb_en;
  logic same_rd;
  logic wb_clr;
  logic issue_free;
  logic issue_acc;

  assign wb_en   = wb_valid & (wb_rd != '0);
  assign same_rd = wb_en & (wb_rd == issue_rd);
  assign wb_clr  = wb_en & busy_q[wb_rd];

`ifdef REGFILE_BYPASS_EN
  // A write-back retiring this cycle frees the register for a new reservation.
  assign issue_free = ~busy_q[issue_rd] | same_rd;
`else
  assign issue_free = ~busy_q[issue_rd] & ~same_rd;
`endif

  assign issue_ready = issue_valid & ((issue_rd == '0) | issue_free);
  assign issue_acc   = issue_ready & (issue_rd != '0);

  // Issue is applied after write-back so a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)     busy_d[wb_rd]    = 1'b0;
    if (issue_acc) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({issue_acc, wb_clr})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q | (wb_en & ~busy_q[wb_rd]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? '0 : XLEN'(RESET_BASE + i);
      end
    end else if (wb_en) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pending_count = cnt_q;
  assign wb_err        = err_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          fwd;
    assign addr = rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign fwd = wb_en & (addr == wb_rd);
`else
    assign fwd = 1'b0;
`endif
    assign rd_data[p*XLEN +: XLEN] = fwd ? wb_data : regs_q[addr];
    assign rd_busy[p]              = busy_q[addr] & ~fwd;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_chk
    assign register_check[i*XLEN +: XLEN] = regs_q[i];
  end

endmodule
